// File: rtl/mul_dot_accum.sv
// Saturating dot-product accumulator for multiplier products; result 1 cycle after the final accept.
// Result held on out_valid until taken; in_ready passes out_ready through while a result is pending.
module mul_dot_accum #(
  parameter  int PROD_W = 5,
  parameter  int ACC_W  = 12,
  parameter  int LEN    = 8,
  localparam int CNT_W  = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept, xfer;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum;

  assign in_ready = !rst && ((state_q == ST_ACC) || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;
  assign prod_ext = ACC_W'(in_prod);
  assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (sum[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (in_last || (cnt_q == CNT_W'(LEN - 1))) begin
            out_acc_d   = acc_d;
            out_count_d = cnt_d;
            out_ovf_d   = ovf_d;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (xfer) begin
          // An accept alongside the transfer opens the next group with this product.
          if (accept) begin
            acc_d = prod_ext;
            cnt_d = CNT_W'(1);
            ovf_d = 1'b0;
            if (in_last || (LEN == 1)) begin
              out_acc_d   = prod_ext;
              out_count_d = CNT_W'(1);
              out_ovf_d   = 1'b0;
            end else begin
              out_valid_d = 1'b0;
              state_d     = ST_ACC;
            end
          end else begin
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
          end
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mul_dot_accum.sv
// Bench for mul_dot_accum: a 12-bit and a 6-bit accumulator (LEN=4) share one stimulus stream.
module tb_mul_dot_accum;

  localparam int LEN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_prod;
  logic        in_last;
  logic        out_ready;

  logic        rdy12, vld12, ovf12;
  logic [11:0] acc12;
  logic [2:0]  cnt12;
  logic        rdy6, vld6, ovf6;
  logic [5:0]  acc6;
  logic [2:0]  cnt6;

  always #5 clk = ~clk;

  mul_dot_accum #(.PROD_W(5), .ACC_W(12), .LEN(LEN)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy12), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld12), .out_ready(out_ready), .out_acc(acc12),
    .out_count(cnt12), .out_ovf(ovf12)
  );

  mul_dot_accum #(.PROD_W(5), .ACC_W(6), .LEN(LEN)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy6), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld6), .out_ready(out_ready), .out_acc(acc6),
    .out_count(cnt6), .out_ovf(ovf6)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference: products of the open group, and the pending result as a plain sum.
  int grp[$];
  bit pend    = 1'b0;
  bit was_rst = 1'b1;
  int e_sum   = 0;
  int e_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int s, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (s > mx) ? mx : s;
  endfunction

  task automatic step(input bit r, input bit v, input int p, input bit l, input bit o);
    bit erdy;
    rst       = r;
    in_valid  = v;
    in_prod   = 5'(p);
    in_last   = l;
    out_ready = o;
    @(negedge clk);
    erdy = !r && (!pend || o);
    chk("in_ready12", 32'(rdy12), 32'(erdy));
    chk("in_ready6", 32'(rdy6), 32'(erdy));
    chk("out_valid12", 32'(vld12), 32'(pend));
    chk("out_valid6", 32'(vld6), 32'(pend));
    if (pend || was_rst) begin
      chk("out_acc12", 32'(acc12), 32'(sat(e_sum, 12)));
      chk("out_count12", 32'(cnt12), 32'(e_cnt));
      chk("out_ovf12", 32'(ovf12), 32'(e_sum > 4095));
      chk("out_acc6", 32'(acc6), 32'(sat(e_sum, 6)));
      chk("out_count6", 32'(cnt6), 32'(e_cnt));
      chk("out_ovf6", 32'(ovf6), 32'(e_sum > 63));
    end
    if (r) begin
      grp.delete();
      pend    = 1'b0;
      e_sum   = 0;
      e_cnt   = 0;
      was_rst = 1'b1;
    end else begin
      was_rst = 1'b0;
      if (pend && o) pend = 1'b0;
      if (v && erdy) begin
        grp.push_back(p);
        if (l || grp.size() == LEN) begin
          e_sum = grp.sum();
          e_cnt = grp.size();
          pend  = 1'b1;
          grp.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    // reset values, then ready released
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // full group of maximal products: 84 on 12-bit, 63 saturated on 6-bit
    for (int i = 0; i < 4; i++) step(0, 1, 21, 0, 0);
    step(0, 0, 0, 0, 1);
    // early close on in_last
    step(0, 1, 5, 0, 0);
    step(0, 1, 7, 1, 0);
    // backpressure, then transfer with a same-cycle accept
    for (int i = 0; i < 3; i++) step(0, 1, 9, 0, 0);
    step(0, 1, 9, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    // group after a saturated group starts clean
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    // in_last on the LEN-th term closes only once
    for (int i = 0; i < 3; i++) step(0, 1, 2, 0, 0);
    step(0, 1, 2, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    // reset mid-group discards the partial sum
    step(0, 1, 10, 0, 0);
    step(0, 1, 10, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 1);
    // reset while a result is pending
    for (int i = 0; i < 2; i++) step(0, 1, 4, i == 1, 0);
    step(1, 1, 4, 0, 0);
    step(0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 60) == 0, ($urandom % 4) != 0, int'($urandom_range(0, 21)),
           ($urandom % 5) == 0, ($urandom % 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
